// File: rtl/dp_pkg.sv
// Shared definitions for the warp ALU datapath: opcodes, illegal-op tag,
// pipeline stage record and the opcode write-enable helper.
package dp_pkg;

  localparam int DP_WARP_W = 8;
  localparam int DP_DATA_W = 32;
  localparam int DP_OP_W   = 4;

  localparam logic [3:0] OP_LOAD  = 4'd0;
  localparam logic [3:0] OP_ADD   = 4'd1;
  localparam logic [3:0] OP_SUB   = 4'd2;
  localparam logic [3:0] OP_AND   = 4'd3;
  localparam logic [3:0] OP_OR    = 4'd4;
  localparam logic [3:0] OP_XOR   = 4'd5;
  localparam logic [3:0] OP_SHL   = 4'd6;
  localparam logic [3:0] OP_SHR   = 4'd7;
  localparam logic [3:0] OP_READ  = 4'd8;
  localparam logic [3:0] OP_CLEAR = 4'd9;

  // Upper half of the result returned for opcodes 10..15.
  localparam logic [15:0] ILLEGAL_TAG = 16'hDEAD;

  // One pipeline stage: a result travelling towards the consumer.
  typedef struct packed {
    logic                 valid;
    logic [DP_WARP_W-1:0] warp;
    logic [DP_DATA_W-1:0] data;
  } dp_stage_t;

  // True for opcodes whose result is written back to the accumulator.
  function automatic logic op_writes(input logic [3:0] op);
    logic wr;
    case (op)
      OP_LOAD, OP_ADD, OP_SUB, OP_AND, OP_OR,
      OP_XOR, OP_SHL, OP_SHR, OP_CLEAR: wr = 1'b1;
      default:                          wr = 1'b0;
    endcase
    return wr;
  endfunction

endpackage

// File: rtl/warp_acc_file.sv
// Per-warp accumulator storage: asynchronous read, synchronous write.
// Storage is never reset; a per-warp written bit (cleared by rstn) makes
// an accumulator read as zero until its first write after reset.
module warp_acc_file
  import dp_pkg::*;
#(
  parameter int WARP_W = DP_WARP_W,
  parameter int DATA_W = DP_DATA_W
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [WARP_W-1:0] rd_warp,
  output logic [DATA_W-1:0] rd_data,
  input  logic              wr_en,
  input  logic [WARP_W-1:0] wr_warp,
  input  logic [DATA_W-1:0] wr_data
);

  localparam int DEPTH = 2 ** WARP_W;

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [DEPTH-1:0]  written_r;

  // Accumulator storage write; contents are qualified by written_r.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_r[wr_warp] <= wr_data;
    end else begin
      mem_r[wr_warp] <= mem_r[wr_warp];
    end
  end

  // Written-bit tracking; reset makes every accumulator read as zero.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      written_r <= '0;
    end else if (wr_en) begin
      written_r[wr_warp] <= 1'b1;
    end else begin
      written_r <= written_r;
    end
  end

  // Read-as-zero mux for accumulators not written since reset.
  always_comb begin
    rd_data = '0;
    if (written_r[rd_warp]) begin
      rd_data = mem_r[rd_warp];
    end else begin
      rd_data = '0;
    end
  end

endmodule

// File: rtl/warp_alu_datapath.sv
// Fixed-latency per-warp accumulator ALU. The accumulator is read, updated
// and written in the accept cycle, so back-to-back commands to one warp need
// no forwarding. Results travel through LATENCY stages and the whole pipe
// freezes while the consumer holds off a valid result.
module warp_alu_datapath
  import dp_pkg::*;
#(
  parameter int LATENCY = 3,
  parameter int WARP_W  = DP_WARP_W,
  parameter int DATA_W  = DP_DATA_W,
  parameter int OP_W    = DP_OP_W
) (
  input  logic                             clk,
  input  logic                             rstn,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [WARP_W-1:0]                in_warp,
  input  logic [OP_W-1:0]                  in_op,
  input  logic [DATA_W-1:0]                in_imm,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [WARP_W-1:0]                out_warp,
  output logic [DATA_W-1:0]                out_data,
  output logic [$clog2(LATENCY+1)-1:0]     inflight
);

  localparam int CNT_W = $clog2(LATENCY + 1);

  dp_stage_t         stage_r [LATENCY];
  logic [CNT_W-1:0]  inflight_r;
  logic              stall_s;
  logic              accept_s;
  logic              out_fire_s;
  logic [DATA_W-1:0] acc_rd_s;
  logic [DATA_W-1:0] res_s;
  logic              wr_s;

  assign stall_s    = stage_r[LATENCY-1].valid && !out_ready;
  assign accept_s   = in_valid && !stall_s;
  assign out_fire_s = stage_r[LATENCY-1].valid && out_ready;

  assign in_ready  = !stall_s;
  assign out_valid = stage_r[LATENCY-1].valid;
  assign out_warp  = stage_r[LATENCY-1].warp;
  assign out_data  = stage_r[LATENCY-1].data;
  assign inflight  = inflight_r;

  warp_acc_file #(
    .WARP_W (WARP_W),
    .DATA_W (DATA_W)
  ) u_acc (
    .clk     (clk),
    .rstn    (rstn),
    .rd_warp (in_warp),
    .rd_data (acc_rd_s),
    .wr_en   (accept_s && wr_s),
    .wr_warp (in_warp),
    .wr_data (res_s)
  );

  // ALU: result from the issuing warp's accumulator and the immediate.
  always_comb begin
    res_s = '0;
    wr_s  = op_writes(in_op);
    case (in_op)
      OP_LOAD:  res_s = in_imm;
      OP_ADD:   res_s = acc_rd_s + in_imm;
      OP_SUB:   res_s = acc_rd_s - in_imm;
      OP_AND:   res_s = acc_rd_s & in_imm;
      OP_OR:    res_s = acc_rd_s | in_imm;
      OP_XOR:   res_s = acc_rd_s ^ in_imm;
      OP_SHL:   res_s = acc_rd_s << in_imm[4:0];
      OP_SHR:   res_s = acc_rd_s >> in_imm[4:0];
      OP_READ:  res_s = acc_rd_s;
      OP_CLEAR: res_s = '0;
      default:  res_s = {ILLEGAL_TAG, {(DATA_W-16-OP_W){1'b0}}, in_op};
    endcase
  end

  // Result shift register; every stage holds while the output is stalled.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < LATENCY; i++) begin
        stage_r[i] <= '0;
      end
    end else if (!stall_s) begin
      stage_r[0].valid <= accept_s;
      stage_r[0].warp  <= in_warp;
      stage_r[0].data  <= res_s;
      for (int i = 1; i < LATENCY; i++) begin
        stage_r[i] <= stage_r[i-1];
      end
    end else begin
      for (int i = 0; i < LATENCY; i++) begin
        stage_r[i] <= stage_r[i];
      end
    end
  end

  // Count of occupied stages: up on accept, down on output handshake.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      inflight_r <= '0;
    end else if (accept_s && !out_fire_s) begin
      inflight_r <= inflight_r + CNT_W'(1'b1);
    end else if (!accept_s && out_fire_s) begin
      inflight_r <= inflight_r - CNT_W'(1'b1);
    end else begin
      inflight_r <= inflight_r;
    end
  end

endmodule
